fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen_pkg.sv | 21 ++
 rtl/fetch_pc_gen_if.sv | 34 +++
 rtl/fetch_pc_gen_hist_ring.sv | 49 ++++
 rtl/fetch_pc_gen.sv | 130 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: FSM state encoding,
// next-PC source select and the default boot address.
package fetch_pc_gen_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_TRAP  = 3'd0,
    SRC_REDIR = 3'd1,
    SRC_PEND  = 3'd2,
    SRC_HOLD  = 3'd3,
    SRC_INC   = 3'd4
  } pc_src_e;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Bundle between the fetch PC generator and its surroundings.
// Handshake: redirect_valid / trap_valid are single-cycle requests with no
// ready; they are sampled on every rising edge. stall acts as an inverted
// ready for pc_out: pc_out is consumed on an edge only when pc_valid=1 and
// stall=0. state_dbg exposes the internal FSM state.
interface fetch_pc_gen_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned HIST_DEPTH = 4
);
  localparam int unsigned IDXW = $clog2(HIST_DEPTH);

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [IDXW-1:0] hist_idx;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic            pend_valid;
  logic            misalign_err;
  logic [XLEN-1:0] hist_pc;
  logic [1:0]      state_dbg;

  modport master (
    output stall, redirect_valid, redirect_pc, trap_valid, trap_pc, hist_idx,
    input  pc_out, pc_valid, pend_valid, misalign_err, hist_pc, state_dbg
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, trap_valid, trap_pc, hist_idx,
    output pc_out, pc_valid, pend_valid, misalign_err, hist_pc, state_dbg
  );
endinterface

// File: rtl/fetch_pc_gen_hist_ring.sv
// pc_hist_ring: ring of recently retired PCs. Entry 0 of the read index is
// the most recent push; older entries follow.
module pc_hist_ring #(
  parameter int unsigned         XLEN     = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]          rd_pc
);
  localparam int unsigned IDXW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [IDXW-1:0] wptr_q, wptr_d;
  logic [IDXW-1:0] rd_addr;

  // Write the pushed PC at the pointer and advance; DEPTH is a power of 2 so
  // the pointer wraps naturally.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (push) begin
      mem_d[wptr_q] = push_pc;
      wptr_d        = wptr_q + IDXW'(1);
    end
  end

  // Storage and pointer registers; every entry boots holding RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= RESET_PC;
    end else begin
      wptr_q <= wptr_d;
      mem_q  <= mem_d;
    end
  end

  // Newest-first read: index 0 is the slot just behind the write pointer.
  always_comb begin
    rd_addr = wptr_q - IDXW'(1) - rd_idx;
    rd_pc   = mem_q[rd_addr];
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction fetch PC generator with trap/redirect priority,
// stall-time redirect latching and target alignment.
// Optional feature: define FETCH_PC_HIST_EN to build the retired-PC history
// ring; otherwise hist_pc reads as 0 and hist_idx is ignored.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     INC        = 4,
  parameter int unsigned     HIST_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_pc_gen_if.slave bus
);
  localparam logic [1:0]      S_BOOT     = ST_BOOT;
  localparam logic [1:0]      S_RUN      = ST_RUN;
  localparam logic [1:0]      S_HOLD     = ST_HOLD;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            misalign_q, misalign_d;
  pc_src_e         src;

  // Pick where the next PC comes from, highest priority first.
  always_comb begin
    src = SRC_INC;
    if (bus.trap_valid)                           src = SRC_TRAP;
    else if (bus.redirect_valid && !bus.stall)    src = SRC_REDIR;
    else if (pend_valid_q && !bus.stall)          src = SRC_PEND;
    else if (bus.stall || (state_q == S_BOOT))    src = SRC_HOLD;
  end

  // Next PC; redirect and trap targets are forced onto an INC boundary.
  always_comb begin
    pc_d = pc_q;
    case (src)
      SRC_TRAP:  pc_d = bus.trap_pc & ~ALIGN_MASK;
      SRC_REDIR: pc_d = bus.redirect_pc & ~ALIGN_MASK;
      SRC_PEND:  pc_d = pend_pc_q;
      SRC_HOLD:  pc_d = pc_q;
      SRC_INC:   pc_d = pc_q + INC_V;
      default:   pc_d = pc_q;
    endcase
  end

  // Pending redirect: latched while stalled, dropped by a trap, consumed
  // (or superseded by a live redirect) on the first unstalled edge.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (bus.trap_valid) begin
      pend_valid_d = 1'b0;
    end else if (bus.redirect_valid && bus.stall) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = bus.redirect_pc & ~ALIGN_MASK;
    end else if (!bus.stall) begin
      pend_valid_d = 1'b0;
    end
  end

  // Misalignment flag checks only the target that actually wins.
  always_comb begin
    if (bus.trap_valid) misalign_d = |(bus.trap_pc & ALIGN_MASK);
    else                misalign_d = bus.redirect_valid && |(bus.redirect_pc & ALIGN_MASK);
  end

  // FSM: one BOOT cycle, then RUN/HOLD follow stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = bus.stall ? S_HOLD : S_RUN;
      S_HOLD:  state_d = bus.stall ? S_HOLD : S_RUN;
      default: state_d = S_BOOT;
    endcase
    pc_valid_d = (state_d != S_BOOT);
  end

  // State registers; reset also discards any pending redirect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= RESET_PC;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_valid     = pc_valid_q;
  assign bus.pend_valid   = pend_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.state_dbg    = state_q;

`ifdef FETCH_PC_HIST_EN
  logic hist_push;
  assign hist_push = (state_q == S_RUN) && !bus.stall;

  pc_hist_ring #(
    .XLEN     (XLEN),
    .DEPTH    (HIST_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .push    (hist_push),
    .push_pc (pc_q),
    .rd_idx  (bus.hist_idx),
    .rd_pc   (bus.hist_pc)
  );
`else
  assign bus.hist_pc = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed testbench for fetch_pc_gen. Build with +define+FETCH_PC_HIST_EN
// to exercise the history ring; otherwise hist_pc is expected to read 0.
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_pc;

  fetch_pc_gen_if #(.XLEN(32), .HIST_DEPTH(4)) bus ();

  fetch_pc_gen #(
    .XLEN       (32),
    .RESET_PC   (RST_PC),
    .INC        (4),
    .HIST_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: outputs are sampled and inputs driven 1 time unit after
  // the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.trap_valid     = 1'b0;
    bus.trap_pc        = '0;
    bus.hist_idx       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #12;
    compared++; if (bus.pc_out !== RST_PC) begin mismatched++; $display("FAIL reset_pc got %h exp %h", bus.pc_out, RST_PC); end
    compared++; if (bus.pc_valid !== 1'b0) begin mismatched++; $display("FAIL reset_pc_valid got %b exp 0", bus.pc_valid); end
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("FAIL reset_pend got %b exp 0", bus.pend_valid); end
    compared++; if (bus.misalign_err !== 1'b0) begin mismatched++; $display("FAIL reset_misalign got %b exp 0", bus.misalign_err); end
    compared++; if (bus.state_dbg !== 2'd0) begin mismatched++; $display("FAIL reset_state got %0d exp 0", bus.state_dbg); end
`ifdef FETCH_PC_HIST_EN
    exp_pc = RST_PC;
`else
    exp_pc = 32'h0;
`endif
    for (int i = 0; i < 4; i++) begin
      bus.hist_idx = 2'(i);
      #1;
      compared++; if (bus.hist_pc !== exp_pc) begin mismatched++; $display("FAIL reset_hist[%0d] got %h exp %h", i, bus.hist_pc, exp_pc); end
    end
    bus.hist_idx = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    // BOOT cycle right after reset release
    compared++; if (bus.pc_valid !== 1'b0) begin mismatched++; $display("FAIL boot_pc_valid got %b exp 0", bus.pc_valid); end
    compared++; if (bus.state_dbg !== 2'd0) begin mismatched++; $display("FAIL boot_state got %0d exp 0", bus.state_dbg); end
    exp_q.push_back(32'h4000_0000);
    exp_q.push_back(32'h4000_0004);
    exp_q.push_back(32'h4000_0008);
    exp_q.push_back(32'h4000_000C);
    exp_q.push_back(32'h4000_0010);
    while (exp_q.size() > 0) begin
      step();
      exp_pc = exp_q.pop_front();
      compared++; if (bus.pc_out !== exp_pc) begin mismatched++; $display("FAIL seq_pc got %h exp %h", bus.pc_out, exp_pc); end
      compared++; if (bus.pc_valid !== 1'b1) begin mismatched++; $display("FAIL seq_pc_valid got %b exp 1", bus.pc_valid); end
    end
  endtask

  task automatic test_stall_redirect();
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_0100;
    step();
    bus.redirect_valid = 1'b0;
    compared++; if (bus.state_dbg !== 2'd2) begin mismatched++; $display("FAIL stall_state got %0d exp 2", bus.state_dbg); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (bus.pc_out !== 32'h4000_0010) begin mismatched++; $display("FAIL stall_hold[%0d] got %h exp 40000010", i, bus.pc_out); end
      compared++; if (bus.pend_valid !== 1'b1) begin mismatched++; $display("FAIL stall_pend[%0d] got %b exp 1", i, bus.pend_valid); end
      if (i < 2) step();
    end
    bus.stall = 1'b0;
    step();
    compared++; if (bus.pc_out !== 32'h4000_0100) begin mismatched++; $display("FAIL pend_apply got %h exp 40000100", bus.pc_out); end
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("FAIL pend_clear got %b exp 0", bus.pend_valid); end
    step();
    compared++; if (bus.pc_out !== 32'h4000_0104) begin mismatched++; $display("FAIL post_pend_inc got %h exp 40000104", bus.pc_out); end
  endtask

  task automatic test_trap();
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_0300;
    step();
    compared++; if (bus.pend_valid !== 1'b1) begin mismatched++; $display("FAIL trap_setup_pend got %b exp 1", bus.pend_valid); end
    bus.redirect_pc = 32'h4000_0400;
    bus.trap_valid  = 1'b1;
    bus.trap_pc     = 32'h0000_0200;
    step();
    compared++; if (bus.pc_out !== 32'h0000_0200) begin mismatched++; $display("FAIL trap_pc got %h exp 00000200", bus.pc_out); end
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("FAIL trap_pend got %b exp 0", bus.pend_valid); end
    clear_inputs();
    step();
    compared++; if (bus.pc_out !== 32'h0000_0204) begin mismatched++; $display("FAIL trap_after got %h exp 00000204", bus.pc_out); end
  endtask

  task automatic test_misalign();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000_0102;
    step();
    clear_inputs();
    compared++; if (bus.pc_out !== 32'h4000_0100) begin mismatched++; $display("FAIL misalign_pc got %h exp 40000100", bus.pc_out); end
    compared++; if (bus.misalign_err !== 1'b1) begin mismatched++; $display("FAIL misalign_pulse got %b exp 1", bus.misalign_err); end
    step();
    compared++; if (bus.misalign_err !== 1'b0) begin mismatched++; $display("FAIL misalign_end got %b exp 0", bus.misalign_err); end
    compared++; if (bus.pc_out !== 32'h4000_0104) begin mismatched++; $display("FAIL misalign_next got %h exp 40000104", bus.pc_out); end
    bus.trap_valid = 1'b1;
    bus.trap_pc    = 32'h0000_0301;
    step();
    clear_inputs();
    compared++; if (bus.pc_out !== 32'h0000_0300) begin mismatched++; $display("FAIL misalign_trap_pc got %h exp 00000300", bus.pc_out); end
    compared++; if (bus.misalign_err !== 1'b1) begin mismatched++; $display("FAIL misalign_trap got %b exp 1", bus.misalign_err); end
    step();
    compared++; if (bus.misalign_err !== 1'b0) begin mismatched++; $display("FAIL misalign_trap_end got %b exp 0", bus.misalign_err); end
  endtask

  task automatic test_latest_wins();
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h5000_0000;
    step();
    bus.redirect_pc = 32'h6000_0004;
    step();
    compared++; if (bus.pc_out !== 32'h0000_0304) begin mismatched++; $display("FAIL latest_hold got %h exp 00000304", bus.pc_out); end
    compared++; if (bus.pend_valid !== 1'b1) begin mismatched++; $display("FAIL latest_pend got %b exp 1", bus.pend_valid); end
    clear_inputs();
    step();
    compared++; if (bus.pc_out !== 32'h6000_0004) begin mismatched++; $display("FAIL latest_apply got %h exp 60000004", bus.pc_out); end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    compared++; if (bus.pc_out !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_top got %h exp fffffffc", bus.pc_out); end
    step();
    compared++; if (bus.pc_out !== 32'h0000_0000) begin mismatched++; $display("FAIL wrap_zero got %h exp 00000000", bus.pc_out); end
    step();
    compared++; if (bus.pc_out !== 32'h0000_0004) begin mismatched++; $display("FAIL wrap_next got %h exp 00000004", bus.pc_out); end
  endtask

  task automatic test_history();
    do_reset();
    // First edge leaves BOOT; the next six each push the current PC.
    for (int i = 0; i < 7; i++) step();
    compared++; if (bus.pc_out !== 32'h4000_0018) begin mismatched++; $display("FAIL hist_pc_out got %h exp 40000018", bus.pc_out); end
    for (int i = 0; i < 4; i++) begin
      bus.hist_idx = 2'(i);
      #1;
`ifdef FETCH_PC_HIST_EN
      exp_pc = 32'h4000_0014 - 32'(4 * i);
`else
      exp_pc = 32'h0;
`endif
      compared++; if (bus.hist_pc !== exp_pc) begin mismatched++; $display("FAIL hist[%0d] got %h exp %h", i, bus.hist_pc, exp_pc); end
    end
    bus.hist_idx = '0;
  endtask

  task automatic test_async_reset();
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h7000_0000;
    step();
    compared++; if (bus.pend_valid !== 1'b1) begin mismatched++; $display("FAIL arst_setup got %b exp 1", bus.pend_valid); end
    #3;
    rst = 1'b1;
    #1;
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("FAIL arst_pend got %b exp 0", bus.pend_valid); end
    compared++; if (bus.pc_out !== RST_PC) begin mismatched++; $display("FAIL arst_pc got %h exp %h", bus.pc_out, RST_PC); end
    compared++; if (bus.state_dbg !== 2'd0) begin mismatched++; $display("FAIL arst_state got %0d exp 0", bus.state_dbg); end
    step();
    clear_inputs();
    rst = 1'b0;
    step();
    compared++; if (bus.pc_out !== RST_PC) begin mismatched++; $display("FAIL arst_resume got %h exp %h", bus.pc_out, RST_PC); end
    compared++; if (bus.pc_valid !== 1'b1) begin mismatched++; $display("FAIL arst_valid got %b exp 1", bus.pc_valid); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_trap();
    test_misalign();
    test_latest_wins();
    test_wrap();
    test_history();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
